// File: rtl/pc16_ras.sv
// 16-bit program counter with a hardware return-address stack for call/return.
// Define PC_BOUND_EN to suppress any next-PC above LIMIT (holds PC, sets ras_err).
module pc16_ras #(
    parameter int unsigned DEPTH = 8,
    parameter logic [15:0] LIMIT = 16'h7FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        inc,
    input  logic        call,
    input  logic        ret,
    output logic [15:0] out,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        ras_err
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || DEPTH > 64) begin : g_depth_check
        $error("pc16_ras: DEPTH must be in 2..64");
    end
    // A zero LIMIT would pin the PC at reset when bounding is enabled.
    if (LIMIT == 16'h0000) begin : g_limit_check
        $error("pc16_ras: LIMIT must be nonzero");
    end

    logic [15:0]   ras [DEPTH];
    logic [PW-1:0] ptr;

    logic [15:0]   out_p1;
    logic [15:0]   nxt_out;
    logic [PW-1:0] nxt_ptr;
    logic          push;
    logic          err_set;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;

    assign out_p1   = out + 16'd1;
    assign push_idx = AW'(ptr);
    assign pop_idx  = AW'(ptr - PW'(1));

    always_comb begin
        nxt_out = out;
        nxt_ptr = ptr;
        push    = 1'b0;
        err_set = 1'b0;
        if (call && ret) begin
            err_set = 1'b1;
        end else if (call) begin
            nxt_out = in;
            if (ras_full) begin
                err_set = 1'b1;
            end else begin
                push    = 1'b1;
                nxt_ptr = ptr + PW'(1);
            end
        end else if (ret) begin
            if (ras_empty) begin
                err_set = 1'b1;
            end else begin
                nxt_ptr = ptr - PW'(1);
                nxt_out = ras[pop_idx];
            end
        end else if (load) begin
            nxt_out = in;
        end else if (inc) begin
            nxt_out = out_p1;
        end
`ifdef PC_BOUND_EN
        // Out-of-range targets are dropped, but a call's push still stands.
        if (nxt_out > LIMIT) begin
            nxt_out = out;
            err_set = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            ptr       <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ras_err   <= 1'b0;
        end else begin
            out       <= nxt_out;
            ptr       <= nxt_ptr;
            ras_empty <= (nxt_ptr == '0);
            ras_full  <= (nxt_ptr == PW'(DEPTH));
            if (err_set) begin
                ras_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras[push_idx] <= out_p1;
        end
    end

endmodule

// File: tb/tb_pc16_ras.sv
// Scoreboard bench for pc16_ras: driver feeds a queue-based reference model,
// monitor compares registered outputs one cycle after each sampled control set.
module tb_pc16_ras;

    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] LIMIT = 16'h00FF;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic        call;
    logic        ret;
    logic [15:0] out;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    pc16_ras #(.DEPTH(DEPTH), .LIMIT(LIMIT)) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
        .load(load),
        .inc(inc),
        .call(call),
        .ret(ret),
        .out(out),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int unsigned m_pc  = 0;
    int unsigned m_stk[$];
    bit          m_err = 1'b0;

    function automatic void model_step(bit r, bit c, bit rt, bit l, bit i, int unsigned d);
        int unsigned cand;
        bit          moves;
        moves = 1'b0;
        cand  = m_pc;
        if (r) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 1'b0;
            return;
        end
        if (c && rt) begin
            m_err = 1'b1;
        end else if (c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % 65536);
            else m_err = 1'b1;
            cand = d; moves = 1'b1;
        end else if (rt) begin
            if (m_stk.size() > 0) begin
                cand = m_stk.pop_back(); moves = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (l) begin
            cand = d; moves = 1'b1;
        end else if (i) begin
            cand = (m_pc + 1) % 65536; moves = 1'b1;
        end
        if (moves) begin
`ifdef PC_BOUND_EN
            if (cand > LIMIT) m_err = 1'b1;
            else m_pc = cand;
`else
            m_pc = cand;
`endif
        end
    endfunction

    task automatic drive(bit r, bit c, bit rt, bit l, bit i, logic [15:0] d);
        exp_t e;
        @(negedge clk);
        reset = r; call = c; ret = rt; load = l; inc = i; in = d;
        model_step(r, c, rt, l, i, d);
        e.pc    = m_pc[15:0];
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == DEPTH);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new registered result after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e.pc || ras_empty !== e.empty || ras_full !== e.full || ras_err !== e.err) begin
                n_fail++;
                $display("FAIL state t=%0t: got out=%h empty=%b full=%b err=%b, expected out=%h empty=%b full=%b err=%b",
                         $time, out, ras_empty, ras_full, ras_err, e.pc, e.empty, e.full, e.err);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned wait_cycles;
        reset = 1'b1; call = 1'b0; ret = 1'b0; load = 1'b0; inc = 1'b0; in = '0;

        drive(1, 0, 0, 0, 0, 16'h0000);
        drive(1, 0, 0, 0, 0, 16'h0000);
        // Reset then three increments
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, 16'h0000);
        // Wrap from 0xFFFF (bounded builds suppress it)
        drive(0, 0, 0, 1, 0, 16'hFFFF);
        drive(0, 0, 0, 0, 1, 16'h0000);
        // Call / return round trip from 0x0010
        drive(0, 0, 0, 1, 0, 16'h0010);
        drive(0, 1, 0, 0, 0, 16'h0200);
        drive(0, 0, 0, 0, 1, 16'h0000);
        drive(0, 0, 0, 0, 1, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h0000);
        // Fill the stack, overflow, then unwind LIFO
        drive(1, 0, 0, 0, 0, 16'h0000);
        for (int k = 0; k < 8; k++) drive(0, 1, 0, 0, 0, 16'h0020 + 16'(k * 16));
        drive(0, 1, 0, 0, 0, 16'h0400);
        for (int k = 0; k < 8; k++) drive(0, 0, 1, 0, 0, 16'h0000);
        // Underflow, call+ret collision, then reset clears the error
        drive(1, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 0, 1, 0, 16'h0005);
        drive(0, 0, 1, 0, 0, 16'h0000);
        drive(0, 1, 1, 1, 1, 16'h0033);
        drive(1, 1, 0, 1, 1, 16'h0044);
        // Limit edge: 0x00FF then increment
        drive(0, 0, 0, 1, 0, 16'h00FF);
        drive(0, 0, 0, 0, 1, 16'h0000);
        drive(0, 0, 1, 0, 1, 16'h0000);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, c, rt, l, i;
            logic [15:0] d;
            r  = ($urandom_range(0, 63) == 0);
            c  = ($urandom_range(0, 3) == 0);
            rt = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 4) == 0);
            i  = ($urandom_range(0, 1) == 0);
            d  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d = d & 16'h01FF;
            drive(r, c, rt, l, i, d);
        end
        drive(0, 0, 0, 0, 0, 16'h0000);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
